// File: rtl/note_sequencer.sv
// note_sequencer: queued note player driving tuneWord/volume with a tick-timed envelope.
// Define NOTE_SEQUENCER_ENVELOPE_EN for ramped attack/release; otherwise volume steps directly.
module note_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          cmdValid,
  output logic                          cmdReady,
  input  logic [15:0]                   cmdTune,
  input  logic [7:0]                    cmdVol,
  input  logic [15:0]                   cmdDur,
  input  logic                          flush,
  output logic [15:0]                   tuneWord,
  output logic [7:0]                    volume,
  output logic                          busy,
  output logic                          noteDone,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [15:0] tune;
    logic [7:0]  vol;
    logic [15:0] dur;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ATTACK, S_SUSTAIN, S_RELEASE} state_t;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_param_check
    $error("note_sequencer: FIFO_DEPTH must be a power of 2 in 2..16, RAMP_STEP in 1..255");
  end

  state_t        r_state, w_state_nxt;
  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_tune, w_tune_nxt;
  logic [7:0]    r_vol, w_vol_nxt;
  logic [7:0]    r_tgt, w_tgt_nxt;
  logic [15:0]   r_dur, w_dur_nxt;
  logic          r_done, w_done_nxt;
  logic          w_push, w_pop, w_more, w_dur_last;
  logic [7:0]    w_vol_up, w_vol_dn;
  cmd_t          w_head;

  assign cmdReady   = (r_count < CW'(FIFO_DEPTH)) && !flush;
  assign w_push     = cmdValid && cmdReady;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_more     = (r_count != '0) && !flush;
  assign w_dur_last = (r_dur == 16'd1);

  assign tuneWord  = r_tune;
  assign volume    = r_vol;
  assign noteDone  = r_done;
  assign fifoCount = r_count;
  assign busy      = (r_state != S_IDLE);

`ifdef NOTE_SEQUENCER_ENVELOPE_EN
  // Saturating ramps: 9-bit sum avoids 8-bit wrap before clamping to target/zero
  localparam logic [8:0] STEP = 9'(RAMP_STEP);
  logic [8:0] w_sum;
  assign w_sum    = {1'b0, r_vol} + STEP;
  assign w_vol_up = (w_sum > {1'b0, r_tgt}) ? r_tgt : w_sum[7:0];
  assign w_vol_dn = ({1'b0, r_vol} > STEP) ? (r_vol - STEP[7:0]) : 8'd0;
`else
  assign w_vol_up = r_tgt;
  assign w_vol_dn = 8'd0;
`endif

  // Command FIFO; flush empties it and blocks pushes via cmdReady
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{tune: cmdTune, vol: cmdVol, dur: cmdDur};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_more) w_state_nxt = S_LOAD;
`ifdef NOTE_SEQUENCER_ENVELOPE_EN
      S_LOAD:    w_state_nxt = flush ? S_RELEASE : S_ATTACK;
`else
      S_LOAD:    w_state_nxt = flush ? S_RELEASE : S_SUSTAIN;
`endif
      S_ATTACK: begin
        if (flush) w_state_nxt = S_RELEASE;
        else if (tick) begin
          if (w_dur_last)             w_state_nxt = S_RELEASE;
          else if (w_vol_up == r_tgt) w_state_nxt = S_SUSTAIN;
        end
      end
      S_SUSTAIN: if (flush || (tick && w_dur_last)) w_state_nxt = S_RELEASE;
      S_RELEASE: if (tick && w_vol_dn == 8'd0) w_state_nxt = w_more ? S_LOAD : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values; duration of 0 is treated as a single tick
  always_comb begin
    w_pop      = 1'b0;
    w_tune_nxt = r_tune;
    w_vol_nxt  = r_vol;
    w_tgt_nxt  = r_tgt;
    w_dur_nxt  = r_dur;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: w_vol_nxt = 8'd0;
      S_LOAD: begin
        w_pop      = 1'b1;
        w_tune_nxt = w_head.tune;
        w_tgt_nxt  = w_head.vol;
        w_dur_nxt  = (w_head.dur == 16'd0) ? 16'd1 : w_head.dur;
`ifndef NOTE_SEQUENCER_ENVELOPE_EN
        w_vol_nxt  = w_head.vol;
`endif
      end
      S_ATTACK: if (!flush && tick) begin
        w_vol_nxt = w_vol_up;
        w_dur_nxt = r_dur - 16'd1;
      end
      S_SUSTAIN: if (!flush && tick) w_dur_nxt = r_dur - 16'd1;
      S_RELEASE: if (tick) begin
        w_vol_nxt  = w_vol_dn;
        w_done_nxt = (w_vol_dn == 8'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tune <= 16'd0;
      r_vol  <= 8'd0;
      r_tgt  <= 8'd0;
      r_dur  <= 16'd0;
      r_done <= 1'b0;
    end else begin
      r_tune <= w_tune_nxt;
      r_vol  <= w_vol_nxt;
      r_tgt  <= w_tgt_nxt;
      r_dur  <= w_dur_nxt;
      r_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed and randomized notes checked against a per-note volume trace model.
module tb_note_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STEP   = 1;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int          STEP_I = int'(STEP);
`ifdef NOTE_SEQUENCER_ENVELOPE_EN
  localparam bit ENV = 1'b1;
`else
  localparam bit ENV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, tick, cmdValid, cmdReady, flush;
  logic [15:0]   cmdTune, cmdDur, tuneWord;
  logic [7:0]    cmdVol, volume;
  logic          busy, noteDone;
  logic [CW-1:0] fifoCount;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  note_sequencer #(.FIFO_DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdTune(cmdTune), .cmdVol(cmdVol), .cmdDur(cmdDur), .flush(flush),
    .tuneWord(tuneWord), .volume(volume), .busy(busy), .noteDone(noteDone),
    .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Release trace from level lvl: ramp down (or drop at once without envelope), at least one tick
  function automatic void add_release(input int lvl);
    int step_r, n;
    step_r = ENV ? STEP_I : 256;
    n = (lvl == 0) ? 1 : (lvl + step_r - 1) / step_r;
    for (int r = 1; r <= n; r++) exp_q.push_back(max_i(lvl - r * step_r, 0));
  endfunction

  // Expected volume after each tick of a note; the last entry is the noteDone tick
  function automatic void build_note(input int v, input int d_raw);
    int d, lvl;
    exp_q.delete();
    d = (d_raw == 0) ? 1 : d_raw;
    if (ENV) begin
      for (int t = 1; t <= d; t++) exp_q.push_back(min_i(t * STEP_I, v));
      lvl = min_i(d * STEP_I, v);
    end else begin
      for (int t = 1; t <= d; t++) exp_q.push_back(v);
      lvl = v;
    end
    add_release(lvl);
  endfunction

  function automatic int pre_vol(input int v);
    return ENV ? 0 : v;
  endfunction

  task automatic tick_once();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic push_cmd(input logic [15:0] t, input logic [7:0] v, input logic [15:0] d);
    int n;
    cmdTune = t; cmdVol = v; cmdDur = d; cmdValid = 1'b1;
    n = 0;
    #1;
    while (!cmdReady && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 64) check("push_ready_timeout", 32'(cmdReady), 32'd1);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic run_note_ticks(input int pre, input bit more);
    int prev, gap, last;
    prev = pre;
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      check("vol_hold", 32'(volume), 32'(prev));
      tick_once();
      check("vol_tick", 32'(volume), 32'(exp_q[i]));
      check("note_done", 32'(noteDone), (i == last) ? 32'd1 : 32'd0);
      prev = exp_q[i];
    end
    check("busy_after_note", 32'(busy), 32'(more));
    if (!more) begin
      @(negedge clk);
      check("done_pulse_len", 32'(noteDone), 32'd0);
    end
  endtask

  // Called one edge before the LOAD pop completes
  task automatic play_note(input logic [15:0] t, input int v, input int d, input bit more);
    build_note(v, d);
    @(negedge clk);
    check("tune_load", 32'(tuneWord), 32'(t));
    check("vol_after_load", 32'(volume), 32'(pre_vol(v)));
    check("busy_in_note", 32'(busy), 32'd1);
    run_note_ticks(pre_vol(v), more);
  endtask

  initial begin
    logic [15:0] ft [5];
    int          fv [5];
    int          fd [5];
    logic [15:0] rt;
    int          rv, rd;

    reset = 1'b1; tick = 1'b0; cmdValid = 1'b0; flush = 1'b0;
    cmdTune = '0; cmdVol = '0; cmdDur = '0;
    repeat (2) @(negedge clk);
    check("rst_tune", 32'(tuneWord), 32'd0);
    check("rst_vol", 32'(volume), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(noteDone), 32'd0);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_ready", 32'(cmdReady), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Worked example, attack cut by duration, zero duration at full volume
    push_cmd(16'h0400, 8'd4, 16'd10);
    @(negedge clk);
    play_note(16'h0400, 4, 10, 1'b0);
    push_cmd(16'h1234, 8'd200, 16'd3);
    @(negedge clk);
    play_note(16'h1234, 200, 3, 1'b0);
    push_cmd(16'hBEEF, 8'hFF, 16'd0);
    @(negedge clk);
    play_note(16'hBEEF, 255, 0, 1'b0);

    // Randomized single notes
    for (int k = 0; k < 5; k++) begin
      rt = 16'($urandom);
      rv = int'($urandom_range(0, 40));
      rd = int'($urandom_range(0, 20));
      push_cmd(rt, 8'(rv), 16'(rd));
      @(negedge clk);
      play_note(rt, rv, rd, 1'b0);
    end

    // Fill the FIFO behind a playing note; fifth push waits for the next LOAD pop
    for (int k = 0; k < 5; k++) begin
      ft[k] = 16'($urandom);
      fv[k] = int'($urandom_range(0, 6));
      fd[k] = int'($urandom_range(0, 4));
    end
    push_cmd(16'h2000, 8'd3, 16'd5);
    repeat (2) @(negedge clk);
    check("fill_tune0", 32'(tuneWord), 32'h2000);
    for (int k = 0; k < 4; k++) begin
      push_cmd(ft[k], 8'(fv[k]), 16'(fd[k]));
      check("fifo_fill", 32'(fifoCount), 32'(k + 1));
    end
    #1;
    check("ready_low_full", 32'(cmdReady), 32'd0);
    cmdTune = ft[4]; cmdVol = 8'(fv[4]); cmdDur = 16'(fd[4]); cmdValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fifo_full_hold", 32'(fifoCount), 32'd4);
    end
    build_note(3, 5);
    run_note_ticks(pre_vol(3), 1'b1);
    #1;
    check("ready_low_in_load", 32'(cmdReady), 32'd0);
    @(negedge clk);
    check("count_after_pop", 32'(fifoCount), 32'd3);
    check("tune_fill1", 32'(tuneWord), 32'(ft[0]));
    check("vol_fill1", 32'(volume), 32'(pre_vol(fv[0])));
    @(negedge clk);
    cmdValid = 1'b0;
    check("fifth_accepted", 32'(fifoCount), 32'd4);
    build_note(fv[0], fd[0]);
    run_note_ticks(pre_vol(fv[0]), 1'b1);
    for (int k = 1; k < 5; k++) play_note(ft[k], fv[k], fd[k], k != 4);

    // Flush in SUSTAIN with a simultaneous push
    push_cmd(16'h1111, 8'd2, 16'd50);
    push_cmd(16'h2222, 8'd7, 16'd4);
    push_cmd(16'h3333, 8'd9, 16'd4);
    check("flush_pre_count", 32'(fifoCount), 32'd2);
    check("flush_pre_tune", 32'(tuneWord), 32'h1111);
    build_note(2, 50);
    tick_once();
    check("flush_t1", 32'(volume), 32'(exp_q[0]));
    tick_once();
    check("flush_t2", 32'(volume), 32'(exp_q[1]));
    flush = 1'b1; cmdValid = 1'b1;
    cmdTune = 16'h4444; cmdVol = 8'd5; cmdDur = 16'd5;
    #1;
    check("flush_ready", 32'(cmdReady), 32'd0);
    @(negedge clk);
    flush = 1'b0; cmdValid = 1'b0;
    check("flush_count", 32'(fifoCount), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_vol", 32'(volume), 32'd2);
    check("flush_nodone", 32'(noteDone), 32'd0);
    exp_q.delete();
    add_release(2);
    run_note_ticks(2, 1'b0);
    repeat (3) @(negedge clk);
    check("flush_idle_busy", 32'(busy), 32'd0);
    check("flush_idle_count", 32'(fifoCount), 32'd0);

    // Flush in IDLE drops the push and keeps the last tune
    flush = 1'b1; cmdValid = 1'b1; cmdTune = 16'h5555;
    @(negedge clk);
    flush = 1'b0; cmdValid = 1'b0;
    check("idle_flush_count", 32'(fifoCount), 32'd0);
    @(negedge clk);
    check("idle_flush_busy", 32'(busy), 32'd0);
    check("idle_tune_hold", 32'(tuneWord), 32'h1111);

    // Asynchronous reset in the middle of a note
    push_cmd(16'h6666, 8'd10, 16'd20);
    repeat (2) @(negedge clk);
    tick_once();
    tick_once();
    #2;
    reset = 1'b1;
    #1;
    check("arst_tune", 32'(tuneWord), 32'd0);
    check("arst_vol", 32'(volume), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(noteDone), 32'd0);
    check("arst_count", 32'(fifoCount), 32'd0);
    @(negedge clk);
    check("arst_nodone", 32'(noteDone), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rt = 16'($urandom);
    rv = int'($urandom_range(1, 20));
    rd = int'($urandom_range(1, 10));
    push_cmd(rt, 8'(rv), 16'(rd));
    @(negedge clk);
    play_note(rt, rv, rd, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter RAMP_STEP, default 1, volume change per tick during attack/release.
REQ-003 SHALL have port clk  input  1  single system clock (40 MHz); all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  one-cycle wave-rate strobe (clk/256), the envelope time base.
REQ-006 SHALL have ports cmdValid input 1, cmdReady output 1  command handshake; push occurs when both are high on a clk edge.
REQ-007 SHALL have ports cmdTune input 16, cmdVol input 8, cmdDur input 16  note tune word, target volume, duration in ticks.
REQ-008 SHALL have port flush  input  1  discard queued notes and release the current note.
REQ-009 SHALL have ports tuneWord output 16, volume output 8  drive the wave generator and volume multiplier.
REQ-010 SHALL have ports busy output 1 (state != IDLE), noteDone output 1 (one-cycle pulse), fifoCount output log2(FIFO_DEPTH)+1.

Function
REQ-011 SHALL store commands in a FIFO of FIFO_DEPTH entries, {tune, vol, dur}; cmdReady = (fifoCount < FIFO_DEPTH) & ~flush.
REQ-012 SHALL implement FSM states IDLE, LOAD, ATTACK, SUSTAIN, RELEASE.
REQ-013 IDLE: volume = 0; when fifoCount > 0, go to LOAD next cycle.
REQ-014 LOAD (exactly one cycle): pop FIFO head; tuneWord <= head tune; target <= head vol; durCnt <= max(head dur, 1); go to ATTACK.
REQ-015 ATTACK: on each tick, volume <= min(volume + RAMP_STEP, target), with no 8-bit wrap; once volume == target, go to SUSTAIN; target 0 goes to SUSTAIN on the first tick.
REQ-016 durCnt SHALL decrement by 1 on each tick in ATTACK and SUSTAIN; when it reaches 0, go to RELEASE, including from ATTACK at the current volume.
REQ-017 RELEASE: on each tick, volume <= max(volume - RAMP_STEP, 0); on the tick that reaches 0, pulse noteDone for one clk and go to LOAD if fifoCount > 0, else IDLE.
REQ-018 States and volume SHALL change only on tick cycles, except LOAD/IDLE transitions and flush.
REQ-019 tuneWord SHALL change only in LOAD and hold its last value in IDLE.
REQ-020 A push and a pop in the same cycle SHALL leave fifoCount unchanged; a push at full is impossible because cmdReady is low.
REQ-021 flush SHALL empty the FIFO in the same cycle; any push in that cycle is dropped; ATTACK/SUSTAIN go to RELEASE; LOAD completes its pop, then goes to RELEASE.
REQ-022 A flush in IDLE or RELEASE SHALL have no effect beyond emptying the FIFO.

Reset
REQ-023 Asserting reset SHALL immediately set: state IDLE, FIFO empty, fifoCount 0, tuneWord 0, volume 0, durCnt 0, noteDone 0, busy 0.
REQ-024 Reset mid-note SHALL abandon the note with no noteDone pulse; operation resumes on the first clk edge after deassertion.

Configuration
REQ-025 Macro NOTE_SEQUENCER_ENVELOPE_EN SHALL, when defined, enable the ramped attack/release of REQ-015 and REQ-017.
REQ-026 Without NOTE_SEQUENCER_ENVELOPE_EN, LOAD SHALL set volume <= target directly and go to SUSTAIN; RELEASE SHALL set volume 0 and pulse noteDone on its first tick; RAMP_STEP is unused.

Verification
REQ-027 ENVELOPE_EN, RAMP_STEP=1: push {tune 0x0400, vol 4, dur 10} -> LOAD one cycle later, volume 1,2,3,4 on ticks 1-4, SUSTAIN until tick 10, volume 3,2,1,0 on ticks 11-14, noteDone on tick 14, then IDLE.
REQ-028 Push 5 commands back-to-back with FIFO_DEPTH=4 -> cmdReady low after the 4th push; 5th is accepted only after the LOAD pop; fifoCount never exceeds 4.
REQ-029 ENVELOPE_EN: {vol 200, dur 3} -> volume reaches 3 at tick 3, goes to RELEASE, and reaches 0 at tick 6 with a single noteDone.
REQ-030 3 notes queued, flush asserted in SUSTAIN of note 1 together with cmdValid -> fifoCount 0, push dropped, RELEASE runs, one noteDone, then IDLE.
REQ-031 Without macro: {vol 0xFF, dur 0} -> volume 0xFF right after LOAD, 0 on tick 2, noteDone on tick 2.
REQ-032 Reset asserted during ATTACK mid-cycle -> all outputs zero before the next clk edge, no noteDone; normal sequencing resumes after release.
